// File: rtl/demux_1ton_stream.sv
// demux_1ton_stream
//   Registered 1-to-N stream demultiplexer with a valid/ready handshake on every
//   port. Each accepted input word goes to the channel chosen by i_sel. Every
//   channel has its own 1-entry holding register, so a stalled consumer never
//   blocks or corrupts the other channels.
//
//   Optional feature: define DEMUX_BCAST_EN to add the i_bcast input. A broadcast
//   word is loaded into all channels at once and is never counted as a drop.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   i_data     input word (WIDTH)
//   i_sel      target channel index (SEL_W)
//   i_valid    input word present
//   i_bcast    broadcast request (only with DEMUX_BCAST_EN)
//   i_ready    block can accept; combinational from i_sel/o_ready (and i_bcast)
//   o_data     channel k data = o_data[k*WIDTH +: WIDTH]
//   o_valid    per-channel word present (NCH)
//   o_ready    per-channel consumer ready (NCH)
//   o_err      1-cycle pulse when a word with an out-of-range select is dropped
//   o_drop_cnt saturating count of dropped words
module demux_1ton_stream #(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     i_data,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic                 i_valid,
`ifdef DEMUX_BCAST_EN
  input  logic                 i_bcast,
`endif
  output logic                 i_ready,
  output logic [NCH*WIDTH-1:0] o_data,
  output logic [NCH-1:0]       o_valid,
  input  logic [NCH-1:0]       o_ready,
  output logic                 o_err,
  output logic [7:0]           o_drop_cnt
);

  logic [NCH-1:0] free;
  logic [NCH-1:0] sel_hot;
  logic [NCH-1:0] load;
  logic           sel_ok;
  logic           bcast;
  logic           accept;
  logic           drop;

`ifdef DEMUX_BCAST_EN
  assign bcast = i_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign free = ~o_valid | o_ready;

  // One-hot decode of i_sel; an out-of-range select decodes to all zeros,
  // which doubles as the range check without a width-sensitive compare.
  always_comb begin
    sel_hot = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (i_sel == SEL_W'(k)) sel_hot[k] = 1'b1;
    end
  end

  assign sel_ok = |sel_hot;

  always_comb begin
    i_ready = 1'b1;
    if (bcast)       i_ready = &free;
    else if (sel_ok) i_ready = |(sel_hot & free);
  end

  assign accept = i_valid & i_ready;
  assign drop   = accept & ~bcast & ~sel_ok;

  always_comb begin
    load = '0;
    if (accept) load = bcast ? '1 : sel_hot;
  end

  // A load only happens when the channel is free, so load takes priority over
  // the drain: a same-cycle transfer and load keeps o_valid high with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= '0;
      o_data  <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (load[k]) begin
          o_valid[k]                <= 1'b1;
          o_data[k*WIDTH +: WIDTH]  <= i_data;
        end else if (o_ready[k]) begin
          o_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err      <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_err <= drop;
      if (drop && (o_drop_cnt != 8'hFF)) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_1ton_stream.sv
// tb_demux_1ton_stream
//   Directed bench for demux_1ton_stream: a table of unicast vectors on the
//   default 4-channel instance, a bad-select run on a 3-channel instance,
//   an asynchronous reset mid-stream and, with DEMUX_BCAST_EN, a broadcast case.
module tb_demux_1ton_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // default instance: WIDTH=2, NCH=4, SEL_W=2
  logic [1:0] i_data = '0;
  logic [1:0] i_sel = '0;
  logic       i_valid = 1'b0;
  logic       i_bcast = 1'b0;
  logic       i_ready;
  logic [7:0] o_data;
  logic [3:0] o_valid;
  logic [3:0] o_ready = '1;
  logic       o_err;
  logic [7:0] o_drop_cnt;

  // 3-channel instance for the out-of-range select case
  logic [1:0] d3_data = '0;
  logic [1:0] d3_sel = '0;
  logic       d3_valid = 1'b0;
  logic       d3_ir;
  logic [5:0] d3_odata;
  logic [2:0] d3_ovalid;
  logic [2:0] d3_oready = '1;
  logic       d3_err;
  logic [7:0] d3_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_1ton_stream #(.WIDTH(2), .NCH(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_sel(i_sel), .i_valid(i_valid),
`ifdef DEMUX_BCAST_EN
    .i_bcast(i_bcast),
`endif
    .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .o_err(o_err), .o_drop_cnt(o_drop_cnt)
  );

  demux_1ton_stream #(.WIDTH(2), .NCH(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_data(d3_data), .i_sel(d3_sel), .i_valid(d3_valid),
`ifdef DEMUX_BCAST_EN
    .i_bcast(1'b0),
`endif
    .i_ready(d3_ir), .o_data(d3_odata), .o_valid(d3_ovalid), .o_ready(d3_oready),
    .o_err(d3_err), .o_drop_cnt(d3_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [1:0] data;
    logic       valid;
    logic [3:0] rdy;
    logic       exp_ir;
    logic [3:0] exp_v;
    logic [7:0] exp_d;
  } vec_t;

  vec_t tbl[9];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // sel data val  rdy   -> i_ready o_valid o_data
    tbl[0] = '{2'd2, 2'b11, 1'b1, 4'b1111, 1'b1, 4'b0100, 8'h30}; // route to ch2
    tbl[1] = '{2'd1, 2'b01, 1'b1, 4'b1101, 1'b1, 4'b0010, 8'h34}; // ch1 loaded, ch2 drains
    tbl[2] = '{2'd1, 2'b10, 1'b1, 4'b1101, 1'b0, 4'b0010, 8'h34}; // ch1 stalled: refused
    tbl[3] = '{2'd3, 2'b10, 1'b1, 4'b0101, 1'b1, 4'b1010, 8'hB4}; // ch3 delivered past stall
    tbl[4] = '{2'd1, 2'b10, 1'b1, 4'b1111, 1'b1, 4'b0010, 8'hB8}; // ch1 transfer+load
    tbl[5] = '{2'd0, 2'b11, 1'b0, 4'b1101, 1'b1, 4'b0010, 8'hB8}; // idle, ch1 held
    tbl[6] = '{2'd1, 2'b00, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'hB8}; // idle, ch1 drains
    tbl[7] = '{2'd0, 2'b11, 1'b1, 4'b1110, 1'b1, 4'b0001, 8'hBB}; // ch0 loaded
    tbl[8] = '{2'd0, 2'b01, 1'b1, 4'b1110, 1'b0, 4'b0001, 8'hBB}; // ch0 stalled: refused

    // reset state
    #12;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_data", 32'(o_data), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_cnt", 32'(o_drop_cnt), 32'h0);
    chk("rst3_cnt", 32'(d3_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // unicast routing, stall, throughput
    for (int i = 0; i < 9; i++) begin
      i_sel   = tbl[i].sel;
      i_data  = tbl[i].data;
      i_valid = tbl[i].valid;
      o_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_iready", i), 32'(i_ready), 32'(tbl[i].exp_ir));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(tbl[i].exp_v));
      chk($sformatf("v%0d_data", i), 32'(o_data), 32'(tbl[i].exp_d));
      chk($sformatf("v%0d_err", i), 32'(o_err), 32'h0);
      chk($sformatf("v%0d_cnt", i), 32'(o_drop_cnt), 32'h0);
    end

    // bad select on the 3-channel instance: drops pulse o_err, count saturates
    d3_sel = 2'd3;
    d3_data = 2'b11;
    for (int i = 0; i < 300; i++) begin
      d3_valid = 1'b1;
      #1;
      chk("bad_iready", 32'(d3_ir), 32'h1);
      tick();
      chk("bad_err", 32'(d3_err), 32'h1);
      chk("bad_cnt", 32'(d3_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      chk("bad_valid", 32'(d3_ovalid), 32'h0);
      if (i % 50 == 0) begin
        d3_valid = 1'b0;
        tick();
        chk("bad_err_gap", 32'(d3_err), 32'h0);
      end
    end
    d3_valid = 1'b0;
    tick();
    chk("bad_err_end", 32'(d3_err), 32'h0);
    chk("bad_cnt_end", 32'(d3_cnt), 32'd255);
    // a valid select on the same instance still routes
    d3_sel = 2'd2;
    d3_data = 2'b10;
    d3_valid = 1'b1;
    d3_oready = 3'b011;
    tick();
    d3_valid = 1'b0;
    chk("d3_route_valid", 32'(d3_ovalid), 32'h4);
    chk("d3_route_data", 32'(d3_odata), 32'h20);
    chk("d3_route_cnt", 32'(d3_cnt), 32'd255);

    // reset mid-stream while ch0 of the default instance is stalled with data
    i_valid = 1'b0;
    chk("pre_rst_valid", 32'(o_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'h0);
    chk("mid_rst_data", 32'(o_data), 32'h0);
    chk("mid_rst3_cnt", 32'(d3_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef DEMUX_BCAST_EN
    // broadcast waits for the stalled channel, then loads every channel
    o_ready = 4'b1011;
    i_sel = 2'd2;
    i_data = 2'b01;
    i_valid = 1'b1;
    i_bcast = 1'b0;
    tick();
    chk("bc_pre_valid", 32'(o_valid), 32'h4);
    i_bcast = 1'b1;
    i_sel = 2'd3;
    i_data = 2'b10;
    #1;
    chk("bc_iready_blocked", 32'(i_ready), 32'h0);
    tick();
    chk("bc_held_valid", 32'(o_valid), 32'h4);
    chk("bc_held_data", 32'(o_data), 32'h10);
    o_ready = 4'b1111;
    #1;
    chk("bc_iready_free", 32'(i_ready), 32'h1);
    tick();
    i_valid = 1'b0;
    i_bcast = 1'b0;
    chk("bc_valid", 32'(o_valid), 32'hF);
    chk("bc_data", 32'(o_data), 32'hAA);
    chk("bc_cnt", 32'(o_drop_cnt), 32'h0);
    chk("bc_err", 32'(o_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
